// File: rtl/allocator_pkg.sv
// Shared bridge definitions: page and word widths, packet-buffer request
// layout, end-of-packet decode and the allocator state encoding.
package allocator_pkg;

   localparam int unsigned LL_PG_ASZ = 6;
   localparam logic [LL_PG_ASZ-1:0] LL_ENDPAGE = '1;

   typedef enum logic [1:0] {
      PCC_DATA   = 2'b00,
      PCC_SOP    = 2'b01,
      PCC_EOP    = 2'b10,
      PCC_BADEOP = 2'b11
   } pcc_t;

   typedef struct packed {
      pcc_t        pcc;
      logic [31:0] data;
   } prw_t;

   localparam int unsigned PFW_SZ = $bits(prw_t);

   typedef struct packed {
      logic [1:0]           port;
      logic                 write;
      logic [LL_PG_ASZ+1:0] addr;
      logic [PFW_SZ-1:0]    data;
   } pbr_t;

   localparam int unsigned PBR_SZ = $bits(pbr_t);

   typedef enum logic [2:0] {
      s_idle, s_req, s_reply, s_link, s_write, s_term, s_fib
   } state_t;

   function automatic logic any_eop(input pcc_t pcc);
      return (pcc == PCC_EOP) || (pcc == PCC_BADEOP);
   endfunction

endpackage

// File: rtl/allocator_sd_iohalf.sv
// Half-rate single-entry buffer; c_drdy comes straight from a flop so the
// upstream ready path is fully registered.
module sd_iohalf #(
   parameter int unsigned width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c_srdy,
   output logic             c_drdy,
   input  logic [width-1:0] c_data,
   output logic             p_srdy,
   input  logic             p_drdy,
   output logic [width-1:0] p_data
);

   logic occupied, occ_nxt, drdy_r;
   logic [width-1:0] hold;

   always_comb begin
      occ_nxt = occupied;
      if (!occupied && c_srdy && drdy_r)
         occ_nxt = 1'b1;
      else if (occupied && p_drdy)
         occ_nxt = 1'b0;
   end

   // drdy_r stays low for the first cycle out of reset, then tracks !occupied
   always_ff @(posedge clk) begin
      if (reset) begin
         occupied <= 1'b0;
         drdy_r   <= 1'b0;
      end else begin
         occupied <= occ_nxt;
         drdy_r   <= ~occ_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (c_srdy && drdy_r)
         hold <= c_data;
   end

   assign c_drdy = drdy_r;
   assign p_srdy = occupied;
   assign p_data = hold;

endmodule

// File: rtl/allocator.sv
// Ingress page allocator: pops free pages, writes packet words four lines per
// page, chains pages with link writes and hands the start page to the FIB.
module allocator
   import allocator_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             port_num,
   input  logic                   rx_srdy,
   output logic                   rx_drdy,
   input  logic [PFW_SZ-1:0]      rx_data,
   output logic                   par_srdy,
   input  logic                   par_drdy,
   input  logic                   parr_srdy,
   output logic                   parr_drdy,
   input  logic [LL_PG_ASZ-1:0]   parr_page,
   output logic                   lnp_srdy,
   input  logic                   lnp_drdy,
   output logic [2*LL_PG_ASZ-1:0] lnp_data,
   output logic                   pbwr_srdy,
   input  logic                   pbwr_drdy,
   output logic [PBR_SZ-1:0]      pbwr_data,
   output logic                   a2f_srdy,
   input  logic                   a2f_drdy,
   output logic [LL_PG_ASZ-1:0]   a2f_data
);

   logic              b_srdy, b_drdy;
   logic [PFW_SZ-1:0] b_data;
   prw_t              b_word;
   pbr_t              wr;

   state_t               state, state_nxt;
   logic                 first, first_nxt;
   logic [LL_PG_ASZ-1:0] start, start_nxt, cur, cur_nxt, nxt, nxt_nxt;
   logic [1:0]           lcount, lcount_nxt;

   sd_iohalf #(.width(PFW_SZ)) rx_buf (
      .clk    (clk),
      .reset  (reset),
      .c_srdy (rx_srdy),
      .c_drdy (rx_drdy),
      .c_data (rx_data),
      .p_srdy (b_srdy),
      .p_drdy (b_drdy),
      .p_data (b_data)
   );

   assign b_word = prw_t'(b_data);

   always_comb begin
      wr       = '0;
      wr.data  = b_data;
      wr.addr  = {cur, lcount};
      wr.write = 1'b1;
      wr.port  = port_num;
   end

   assign pbwr_data = wr;
   assign a2f_data  = start;

   always_comb begin
      state_nxt  = state;
      first_nxt  = first;
      start_nxt  = start;
      cur_nxt    = cur;
      nxt_nxt    = nxt;
      lcount_nxt = lcount;
      par_srdy   = 1'b0;
      parr_drdy  = 1'b0;
      lnp_srdy   = 1'b0;
      lnp_data   = {cur, nxt};
      pbwr_srdy  = 1'b0;
      b_drdy     = 1'b0;
      a2f_srdy   = 1'b0;
      case (state)
         s_idle:
            if (b_srdy) state_nxt = s_req;
         s_req: begin
            par_srdy = 1'b1;
            if (par_drdy) state_nxt = s_reply;
         end
         s_reply: begin
            parr_drdy = 1'b1;
            if (parr_srdy) begin
               if (first) begin
                  start_nxt  = parr_page;
                  cur_nxt    = parr_page;
                  lcount_nxt = '0;
                  first_nxt  = 1'b0;
                  state_nxt  = s_write;
               end else begin
                  nxt_nxt   = parr_page;
                  state_nxt = s_link;
               end
            end
         end
         s_link: begin
            lnp_srdy = 1'b1;
            if (lnp_drdy) begin
               cur_nxt    = nxt;
               lcount_nxt = '0;
               state_nxt  = s_write;
            end
         end
         s_write: begin
            pbwr_srdy = b_srdy;
            b_drdy    = pbwr_drdy;
            // end of packet wins over page full, so no spare page is taken
            if (b_srdy && pbwr_drdy) begin
               lcount_nxt = lcount + 2'd1;
               if (any_eop(b_word.pcc))
                  state_nxt = s_term;
               else if (lcount == 2'd3)
                  state_nxt = s_req;
            end
         end
         s_term: begin
            lnp_srdy = 1'b1;
            lnp_data = {cur, LL_ENDPAGE};
            if (lnp_drdy) state_nxt = s_fib;
         end
         s_fib: begin
            a2f_srdy = 1'b1;
            if (a2f_drdy) begin
               first_nxt  = 1'b1;
               lcount_nxt = '0;
               state_nxt  = s_idle;
            end
         end
         default: state_nxt = s_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= s_idle;
         first  <= 1'b1;
         start  <= '0;
         cur    <= '0;
         nxt    <= '0;
         lcount <= '0;
      end else begin
         state  <= state_nxt;
         first  <= first_nxt;
         start  <= start_nxt;
         cur    <= cur_nxt;
         nxt    <= nxt_nxt;
         lcount <= lcount_nxt;
      end
   end

endmodule

// File: tb/tb_allocator.sv
// Scoreboard bench for allocator: expected writes, links and FIB pages are
// queued when a packet is planned and popped by an independent monitor.
module tb_allocator;
   import allocator_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [1:0]             port_num;
   logic                   rx_srdy, rx_drdy;
   logic [PFW_SZ-1:0]      rx_data;
   logic                   par_srdy, par_drdy;
   logic                   parr_srdy, parr_drdy;
   logic [LL_PG_ASZ-1:0]   parr_page;
   logic                   lnp_srdy, lnp_drdy;
   logic [2*LL_PG_ASZ-1:0] lnp_data;
   logic                   pbwr_srdy, pbwr_drdy;
   logic [PBR_SZ-1:0]      pbwr_data;
   logic                   a2f_srdy, a2f_drdy;
   logic [LL_PG_ASZ-1:0]   a2f_data;

   allocator dut (
      .clk       (clk),
      .reset     (reset),
      .port_num  (port_num),
      .rx_srdy   (rx_srdy),
      .rx_drdy   (rx_drdy),
      .rx_data   (rx_data),
      .par_srdy  (par_srdy),
      .par_drdy  (par_drdy),
      .parr_srdy (parr_srdy),
      .parr_drdy (parr_drdy),
      .parr_page (parr_page),
      .lnp_srdy  (lnp_srdy),
      .lnp_drdy  (lnp_drdy),
      .lnp_data  (lnp_data),
      .pbwr_srdy (pbwr_srdy),
      .pbwr_drdy (pbwr_drdy),
      .pbwr_data (pbwr_data),
      .a2f_srdy  (a2f_srdy),
      .a2f_drdy  (a2f_drdy),
      .a2f_data  (a2f_data)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   pbr_t                   exp_wr[$];
   logic [2*LL_PG_ASZ-1:0] exp_ln[$];
   logic [LL_PG_ASZ-1:0]   exp_fib[$];
   logic [LL_PG_ASZ-1:0]   fl_pages[$];
   logic [LL_PG_ASZ-1:0]   plan[$];

   int alloc_cnt = 0;
   int alloc_exp = 0;
   bit mute = 1'b0;
   int mute_wr = 0;
   int bp_pct = 100;
   bit fl_stall = 1'b0;
   bit gaps = 1'b0;
   bit fib_pend = 1'b0;
   int term_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out at cycle %0d", name, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // downstream ready drivers
   initial begin
      pbwr_drdy = 1'b0;
      lnp_drdy  = 1'b0;
      a2f_drdy  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         pbwr_drdy = ($urandom_range(0, 99) < bp_pct);
         lnp_drdy  = ($urandom_range(0, 99) < bp_pct);
         a2f_drdy  = ($urandom_range(0, 99) < bp_pct);
      end
   end

   // free list: hands out pages in the order they were planned
   initial begin
      par_drdy  = 1'b0;
      parr_srdy = 1'b0;
      parr_page = '0;
      forever begin
         @(posedge clk);
         #1;
         par_drdy = !fl_stall && ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (par_srdy && par_drdy && !reset) begin
            int t;
            int d;
            @(posedge clk);
            #1;
            par_drdy = 1'b0;
            alloc_cnt++;
            d = $urandom_range(0, 2);
            for (int k = 0; k < d; k++) begin
               @(posedge clk);
               #1;
            end
            parr_srdy = 1'b1;
            if (fl_pages.size() == 0) begin
               timeout_fail("fl_unexpected_alloc");
               parr_page = '0;
            end else begin
               parr_page = fl_pages.pop_front();
            end
            t = 0;
            @(negedge clk);
            while (!parr_drdy && t < 500) begin
               @(negedge clk);
               t++;
            end
            if (t >= 500) timeout_fail("parr_accept");
            @(posedge clk);
            #1;
            parr_srdy = 1'b0;
         end
      end
   end

   // monitor
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (mute) begin
            if (pbwr_srdy && pbwr_drdy) mute_wr++;
         end else begin
            if (fib_pend && a2f_srdy) begin
               check("fib_latency", 64'(cyc - term_cyc), 64'd1);
               fib_pend = 1'b0;
            end
            if (pbwr_srdy && pbwr_drdy) begin
               if (exp_wr.size() == 0) timeout_fail("pbwr_unexpected");
               else check("pbwr_data", 64'(pbwr_data), 64'(exp_wr.pop_front()));
            end
            if (lnp_srdy && lnp_drdy) begin
               if (exp_ln.size() == 0) timeout_fail("lnp_unexpected");
               else check("lnp_data", 64'(lnp_data), 64'(exp_ln.pop_front()));
               if (lnp_data[LL_PG_ASZ-1:0] == LL_ENDPAGE) begin
                  fib_pend = 1'b1;
                  term_cyc = cyc;
               end
            end
            if (a2f_srdy && a2f_drdy) begin
               if (exp_fib.size() == 0) timeout_fail("a2f_unexpected");
               else check("a2f_data", 64'(a2f_data), 64'(exp_fib.pop_front()));
            end
         end
      end
   end

   task automatic send_word(input prw_t w);
      int t;
      if (gaps) begin
         int g;
         g = $urandom_range(0, 2);
         for (int k = 0; k < g; k++) begin
            rx_srdy = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      rx_srdy = 1'b1;
      rx_data = w;
      t = 0;
      @(negedge clk);
      while (!rx_drdy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) timeout_fail("rx_accept");
      @(posedge clk);
      #1;
      rx_srdy = 1'b0;
   endtask

   task automatic send_packet(input int n);
      int                   np;
      logic [LL_PG_ASZ-1:0] pg[$];
      prw_t                 words[$];
      pbr_t                 e;
      np = (n + 3) / 4;
      for (int k = 0; k < np; k++) begin
         if (plan.size() > 0) pg.push_back(plan.pop_front());
         else pg.push_back(LL_PG_ASZ'($urandom_range(0, 62)));
         fl_pages.push_back(pg[k]);
      end
      alloc_exp += np;
      for (int i = 0; i < n; i++) begin
         prw_t w;
         w.data = $urandom;
         if (i == n - 1) w.pcc = ($urandom_range(0, 1) != 0) ? PCC_EOP : PCC_BADEOP;
         else if (i == 0) w.pcc = PCC_SOP;
         else w.pcc = PCC_DATA;
         words.push_back(w);
         e.port  = port_num;
         e.write = 1'b1;
         e.addr  = {pg[i / 4], 2'(i % 4)};
         e.data  = w;
         exp_wr.push_back(e);
      end
      for (int k = 0; k < np - 1; k++) exp_ln.push_back({pg[k], pg[k + 1]});
      exp_ln.push_back({pg[np - 1], LL_ENDPAGE});
      exp_fib.push_back(pg[0]);
      for (int i = 0; i < n; i++) send_word(words[i]);
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((exp_wr.size() != 0 || exp_ln.size() != 0 || exp_fib.size() != 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) timeout_fail(name);
      repeat (4) @(negedge clk);
      check({name, "_allocs"}, 64'(alloc_cnt), 64'(alloc_exp));
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string name);
      check({name, "_outs"},
            64'({par_srdy, parr_drdy, lnp_srdy, pbwr_srdy, a2f_srdy, rx_drdy}), 64'd0);
      check({name, "_state"}, 64'(dut.state), 64'(s_idle));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      rx_srdy  = 1'b0;
      rx_data  = '0;
      port_num = 2'd1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rx_ready_after_reset", 64'(rx_drdy), 64'd1);
      @(posedge clk);
      #1;

      plan.push_back(6'd5);
      send_packet(1);
      wait_drain("one_word");

      port_num = 2'd2;
      plan.push_back(6'd2);
      send_packet(4);
      wait_drain("four_word");

      port_num = 2'd0;
      plan.push_back(6'd1);
      plan.push_back(6'd6);
      plan.push_back(6'd3);
      send_packet(9);
      wait_drain("nine_word");

      port_num = 2'd3;
      bp_pct   = 60;
      gaps     = 1'b1;
      repeat (30) send_packet($urandom_range(1, 14));
      wait_drain("random");
      bp_pct = 100;
      gaps   = 1'b0;

      port_num = 2'd2;
      fl_stall = 1'b1;
      plan.push_back(6'd7);
      plan.push_back(6'd8);
      fork
         send_packet(8);
         begin
            int t;
            int hi;
            t = 0;
            @(negedge clk);
            while (!par_srdy && t < 200) begin
               @(negedge clk);
               t++;
            end
            if (t >= 200) timeout_fail("stall_req");
            hi = 0;
            repeat (20) begin
               @(negedge clk);
               if (par_srdy) hi++;
            end
            check("stall_par_held", 64'(hi), 64'd20);
            check("stall_rx_backpressure", 64'(rx_drdy), 64'd0);
            @(posedge clk);
            #1;
            fl_stall = 1'b0;
         end
      join
      wait_drain("stall");

      mute    = 1'b1;
      mute_wr = 0;
      fl_pages.push_back(6'd10);
      alloc_exp++;
      send_word('{pcc: PCC_SOP, data: $urandom});
      send_word('{pcc: PCC_DATA, data: $urandom});
      begin
         int t;
         t = 0;
         while (mute_wr < 2 && t < 500) begin
            @(negedge clk);
            t++;
         end
         if (t >= 500) timeout_fail("partial_writes");
      end
      @(negedge clk);
      check("mid_packet_state", 64'(dut.state), 64'(s_write));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_quiet("mid_reset");
      @(posedge clk);
      #1;
      reset    = 1'b0;
      fib_pend = 1'b0;
      fl_pages.delete();
      mute     = 1'b0;
      plan.push_back(6'd44);
      plan.push_back(6'd45);
      send_packet(5);
      wait_drain("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
